// File: rtl/ysyx_220053_seq_ctrl.sv
// ysyx_220053_seq_ctrl
// Multi-cycle control sequencer for the ysyx_220053 RV64 datapath.
// It fetches an instruction and latches it. It decodes lui/addi/lw/sw/ebreak
// into datapath controls. It runs data-memory handshakes, then retires the
// instruction in a one-cycle write-back. The FSM halts on ebreak. It faults
// on an illegal encoding and, when enabled, on a handshake timeout.
//
// Handshake rule: a request (if_req / mem_req) is a level that stays high
// from the first cycle of FETCH/MEM until the cycle in which the matching ack
// is sampled high on a rising edge. The request drops in the next cycle.
// An ack seen while its own request is low has no effect.
//
// Optional feature macro: YSYX_220053_SEQ_TIMEOUT_EN
//   When defined, a wait counter bounds each handshake to TIMEOUT cycles.
//   When the bound is reached with no ack, the FSM goes to FAULT.
//
// Parameters:
//   TIMEOUT  maximum wait cycles per handshake (2..65535)
//   CNT_W    width of the retired-instruction counter
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   if_req/if_ack     instruction fetch handshake, if_rdata valid with ack
//   mem_req/mem_wen   data access request, 1 = store
//   mem_ack           data access complete
//   ir_o              latched instruction register
//   alu_srcb, ext_op  decoded datapath controls (valid DECODE..WB)
//   rf_wen, pc_we     one-cycle write-back strobes
//   halt_o, illegal_o sticky status
//   retired_o         retired-instruction count (wraps)
//   dbg_state_o       current FSM state encoding, for observation
module ysyx_220053_seq_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             if_req,
    input  logic             if_ack,
    input  logic [31:0]      if_rdata,
    output logic             mem_req,
    output logic             mem_wen,
    input  logic             mem_ack,
    output logic [31:0]      ir_o,
    output logic             alu_srcb,
    output logic [2:0]       ext_op,
    output logic             rf_wen,
    output logic             pc_we,
    output logic             halt_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Instruction classification from the latched word.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_lui, is_addi, is_lw, is_sw, is_ebreak, is_legal;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_lui    = (opcode == 7'b0110111);
    assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_ebreak = (ir_q == 32'h0010_0073);
    assign is_legal  = is_lui | is_addi | is_lw | is_sw;

    // Handshake timeout detection.
    logic waiting;
    logic timeout_hit;
    assign waiting = ((state_q == S_FETCH) && !if_ack) ||
                     ((state_q == S_MEM) && !mem_ack);

`ifdef YSYX_220053_SEQ_TIMEOUT_EN
    logic [15:0] wait_q, wait_d;

    // wait_q counts the earlier no-ack cycles in this handshake, so it
    // equals TIMEOUT-1 in the TIMEOUT-th cycle. An ack in that cycle
    // still wins because waiting is false when the ack is present.
    assign timeout_hit = waiting && (wait_q == 16'(TIMEOUT - 1));

    // Any state other than a waiting FETCH/MEM cycle sets the counter
    // to zero, so it restarts at zero on each entry to FETCH or MEM.
    always_comb begin
        wait_d = 16'd0;
        if (waiting && !timeout_hit) begin
            wait_d = wait_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 16'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    wire unused_timeout = (TIMEOUT == 0) | waiting;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            ir_q      <= 32'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        if_req    = 1'b0;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        rf_wen    = 1'b0;
        pc_we     = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if_req = 1'b1;
                if (if_ack) begin
                    ir_d    = if_rdata;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (is_ebreak) begin
                    // ebreak retires on entry to HALT, without write-back strobes.
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_HALT;
                end else if (!is_legal) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM: begin
                mem_req = 1'b1;
                mem_wen = is_sw;
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                pc_we     = 1'b1;
                rf_wen    = is_lui | is_addi | is_lw;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Immediate format and B-source, shown only while an instruction is
    // in flight (DECODE through WB). Illegal and ebreak words give 0.
    logic in_window;
    assign in_window = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        ext_op   = 3'd0;
        alu_srcb = 1'b0;
        if (in_window) begin
            if (is_lui) begin
                ext_op = 3'd1;
            end else if (is_addi || is_lw) begin
                ext_op   = 3'd0;
                alu_srcb = 1'b1;
            end else if (is_sw) begin
                ext_op   = 3'd2;
                alu_srcb = 1'b1;
            end
        end
    end

    // HALT and FAULT are absorbing, so the state alone gives sticky flags.
    assign halt_o      = (state_q == S_HALT);
    assign illegal_o   = (state_q == S_FAULT);
    assign ir_o        = ir_q;
    assign retired_o   = retired_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_220053_seq_ctrl.sv
// Testbench for ysyx_220053_seq_ctrl. The driver tasks run each instruction
// through the handshakes. The expected write-back controls go into a queue
// when an instruction is fetched. A monitor pops and compares them when it
// sees the write-back strobe.
module tb_ysyx_220053_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_wen;
    logic        mem_ack;
    logic [31:0] ir_o;
    logic        alu_srcb;
    logic [2:0]  ext_op;
    logic        rf_wen;
    logic        pc_we;
    logic        halt_o;
    logic        illegal_o;
    logic [31:0] retired_o;
    logic [2:0]  dbg_state_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_retired;
    logic [4:0]  exp_q[$];
    logic [4:0]  sb_e;

    ysyx_220053_seq_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_ack    (mem_ack),
        .ir_o       (ir_o),
        .alu_srcb   (alu_srcb),
        .ext_op     (ext_op),
        .rf_wen     (rf_wen),
        .pc_we      (pc_we),
        .halt_o     (halt_o),
        .illegal_o  (illegal_o),
        .retired_o  (retired_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode: {rf_wen, ext_op, alu_srcb} for a retiring instruction.
    function automatic logic [4:0] model(input logic [31:0] ins);
        if (ins[6:0] == 7'b0110111) return {1'b1, 3'd1, 1'b0};
        if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000) return {1'b1, 3'd0, 1'b1};
        if (ins[6:0] == 7'b0000011 && ins[14:12] == 3'b010) return {1'b1, 3'd0, 1'b1};
        if (ins[6:0] == 7'b0100011 && ins[14:12] == 3'b010) return {1'b0, 3'd2, 1'b1};
        return 5'd0;
    endfunction

    // 0 = ALU/lui, 1 = load, 2 = store, 3 = ebreak, 4 = illegal
    function automatic int kind_of(input logic [31:0] ins);
        if (ins == 32'h0010_0073) return 3;
        if (ins[6:0] == 7'b0000011 && ins[14:12] == 3'b010) return 1;
        if (ins[6:0] == 7'b0100011 && ins[14:12] == 3'b010) return 2;
        if (model(ins) != 5'd0) return 0;
        return 4;
    endfunction

    // Scoreboard monitor: each write-back strobe retires the oldest entry.
    always @(negedge clk) begin
        if (rst_n && pc_we) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_wb", 64'(1), 64'(0));
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_wb_ctl", 64'({rf_wen, ext_op, alu_srcb}), 64'(sb_e));
            end
        end
    end

    // Reset held for two cycles. The task returns at the first FETCH cycle.
    task automatic do_reset();
        rst_n    = 1'b0;
        if_ack   = 1'b0;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_retired = 32'd0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Fetch handshake with fwait no-ack cycles. The task returns at the DECODE negedge.
    task automatic fetch(input logic [31:0] ins, input int fwait, input logic stray);
        int n = 0;
        int cyc = 0;
        while (!if_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (if_req && cyc < 50) begin
            cyc++;
            if_ack   = (cyc > fwait);
            if_rdata = ins;
            mem_ack  = stray;
            @(negedge clk);
            if_ack  = 1'b0;
            mem_ack = 1'b0;
        end
        check("fetch_req_cycles", 64'(cyc), 64'(fwait + 1));
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait,
                             input logic stray);
        logic [4:0] e;
        int kind;
        int cyc;
        e    = model(ins);
        kind = kind_of(ins);
        fetch(ins, fwait, stray);
        check("ir_latch", 64'(ir_o), 64'(ins));
        check("decode_ctl", 64'({ext_op, alu_srcb}), 64'(e[3:0]));
        if (kind == 3) begin
            @(negedge clk);
            exp_retired++;
            check("halt_set", 64'(halt_o), 64'(1));
            check("halt_no_strobe", 64'({rf_wen, pc_we, if_req}), 64'(0));
            check("halt_retired", 64'(retired_o), 64'(exp_retired));
        end else if (kind == 4) begin
            @(negedge clk);
            check("illegal_set", 64'(illegal_o), 64'(1));
            check("illegal_retired", 64'(retired_o), 64'(exp_retired));
        end else begin
            exp_q.push_back(e);
            @(negedge clk);
            check("exec_ctl", 64'({ext_op, alu_srcb}), 64'(e[3:0]));
            check("exec_no_req", 64'({mem_req, if_req, pc_we}), 64'(0));
            @(negedge clk);
            if (kind == 1 || kind == 2) begin
                cyc = 0;
                while (mem_req && cyc < 50) begin
                    cyc++;
                    check("mem_wen", 64'(mem_wen), 64'(kind == 2));
                    mem_ack = (cyc > mwait);
                    @(negedge clk);
                    mem_ack = 1'b0;
                end
                check("mem_req_cycles", 64'(cyc), 64'(mwait + 1));
            end
            check("wb_pc_we", 64'(pc_we), 64'(1));
            check("wb_retired_before", 64'(retired_o), 64'(exp_retired));
            @(negedge clk);
            exp_retired++;
            check("wb_retired_after", 64'(retired_o), 64'(exp_retired));
            check("after_wb_strobes", 64'({rf_wen, pc_we}), 64'(0));
        end
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        if_ack   = 1'b1;
        mem_ack  = 1'b0;
        if_rdata = 32'hFFFF_FFFF;
        exp_retired = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_flags", 64'({if_req, mem_req, mem_wen, rf_wen, pc_we, halt_o, illegal_o, alu_srcb}), 64'(0));
        check("reset_ext_op", 64'(ext_op), 64'(0));
        check("reset_ir", 64'(ir_o), 64'(0));
        check("reset_retired", 64'(retired_o), 64'(0));
        check("reset_state", 64'(dbg_state_o), 64'(0));

        // One cycle in RESET after release, with if_ack held high.
        rst_n = 1'b1;
        check("release_no_req", 64'(if_req), 64'(0));
        @(negedge clk);
        check("req_second_cycle", 64'(if_req), 64'(1));

        run_instr(32'h1234_50B7, 0, 0, 1'b0);   // lui x1,0x12345
        run_instr(32'h0050_0093, 3, 0, 1'b1);   // addi, stray mem_ack during fetch
        run_instr(32'h0000_A103, 0, 0, 1'b0);   // lw
        run_instr(32'h0020_A223, 0, 0, 1'b0);   // sw
        run_instr(32'h0000_A103, 1, 3, 1'b0);   // lw, ack in the 4th MEM cycle
        check("retired_count", 64'(retired_o), 64'(5));
        run_instr(32'h0010_0073, 0, 0, 1'b0);   // ebreak

        // HALT ignores acks and issues no more requests.
        for (int i = 0; i < 5; i++) begin
            if_ack  = 1'b1;
            mem_ack = 1'b1;
            @(negedge clk);
            check("halt_quiet", 64'({if_req, mem_req, rf_wen, pc_we}), 64'(0));
            check("halt_sticky", 64'({halt_o, dbg_state_o}), 64'({1'b1, 3'd6}));
        end
        check("halt_retired_hold", 64'(retired_o), 64'(6));

        // Illegal funct3 on OP-IMM.
        do_reset();
        run_instr(32'h0010_9093, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("fault_sticky", 64'({illegal_o, dbg_state_o}), 64'({1'b1, 3'd7}));
        check("fault_retired", 64'(retired_o), 64'(0));

        // Asynchronous reset in the middle of a MEM wait.
        do_reset();
        fetch(32'h0000_A103, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_mem_req", 64'(mem_req), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_flags", 64'({if_req, mem_req, mem_wen, rf_wen, pc_we, halt_o, illegal_o, alu_srcb}), 64'(0));
        check("async_ir_state", 64'({ir_o, dbg_state_o}), 64'(0));
        check("async_retired", 64'(retired_o), 64'(0));
        @(negedge clk);
        do_reset();

`ifdef YSYX_220053_SEQ_TIMEOUT_EN
        // mem_ack held low: four request cycles, then FAULT.
        fetch(32'h0000_A103, 0, 1'b0);
        repeat (2) @(negedge clk);
        cyc = 0;
        mem_ack = 1'b0;
        while (mem_req && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        check("timeout_mem_cycles", 64'(cyc), 64'(4));
        check("timeout_fault", 64'({illegal_o, dbg_state_o}), 64'({1'b1, 3'd7}));
        check("timeout_retired", 64'(retired_o), 64'(0));
`else
        cyc = 0;
        run_instr(32'h0050_0093, 6, 0, 1'b0);   // long fetch wait without timeout
        check("no_timeout_retired", 64'(retired_o + 32'(cyc)), 64'(1));
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
